// File: rtl/alu_pkg.sv
// Shared types for the decode stage: ALU op encoding, RV32I opcodes and
// the decoded command bundle handed to execute.
package alu_pkg;

   localparam int unsigned XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SRL   = 4'd3,
      ALU_SRA   = 4'd4,
      ALU_AND   = 4'd5,
      ALU_OR    = 4'd6,
      ALU_XOR   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_EQ    = 4'd10,
      ALU_SGE   = 4'd11,
      ALU_SGEU  = 4'd12,
      ALU_PASS1 = 4'd13
   } alu_sel_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef struct packed {
      alu_sel_e         aluselect;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [4:0]       rd;
      logic [XLEN-1:0]  imm;
      logic             src0_pc;
      logic             src1_imm;
      logic             reg_write;
      logic             mem_read;
      logic             mem_write;
      logic             branch;
      logic             jump;
      logic             branch_invert;
      logic             illegal;
   } decoded_t;

   // funct3 -> ALU op for OP / OP_IMM; alt is funct7[5] (sub / sra)
   function automatic alu_sel_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      alu_sel_e sel;
      sel = ALU_ADD;
      case (f3)
         3'd0: sel = alt ? ALU_SUB : ALU_ADD;
         3'd1: sel = ALU_SLL;
         3'd2: sel = ALU_SLT;
         3'd3: sel = ALU_SLTU;
         3'd4: sel = ALU_XOR;
         3'd5: sel = alt ? ALU_SRA : ALU_SRL;
         3'd6: sel = ALU_OR;
         3'd7: sel = ALU_AND;
         default: sel = ALU_ADD;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/alu_decode_stage_if.sv
// Fetch-side and execute-side signals of the decode stage.
// slave = the stage itself, master = the surrounding fetch/execute logic.
interface alu_decode_stage_if #(parameter int unsigned DATA_WIDTH = 32);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_instr;
   logic [DATA_WIDTH-1:0] in_pc;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_pc;
   logic [3:0]            out_aluselect;
   logic [4:0]            out_rs1;
   logic [4:0]            out_rs2;
   logic [4:0]            out_rd;
   logic [DATA_WIDTH-1:0] out_imm;
   logic                  out_src0_pc;
   logic                  out_src1_imm;
   logic                  out_reg_write;
   logic                  out_mem_read;
   logic                  out_mem_write;
   logic                  out_branch;
   logic                  out_jump;
   logic                  out_branch_invert;
   logic                  out_illegal;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_pc, out_aluselect, out_rs1, out_rs2, out_rd,
             out_imm, out_src0_pc, out_src1_imm, out_reg_write, out_mem_read,
             out_mem_write, out_branch, out_jump, out_branch_invert, out_illegal
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_pc, out_aluselect, out_rs1, out_rs2, out_rd,
             out_imm, out_src0_pc, out_src1_imm, out_reg_write, out_mem_read,
             out_mem_write, out_branch, out_jump, out_branch_invert, out_illegal
   );

endinterface

// File: rtl/rv32_decoder.sv
// Purely combinational RV32I decoder: instruction word -> ALU command bundle.
// Register fields a format does not use are reported as 0.
module rv32_decoder
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   output decoded_t        dec
);

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [4:0]      f_rs1;
   logic [4:0]      f_rs2;
   logic [4:0]      f_rd;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_s;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;
   logic [XLEN-1:0] imm_sh;

   assign opcode = instr[6:0];
   assign f_rd   = instr[11:7];
   assign funct3 = instr[14:12];
   assign f_rs1  = instr[19:15];
   assign f_rs2  = instr[24:20];
   assign funct7 = instr[31:25];

   assign imm_i  = {{20{instr[31]}}, instr[31:20]};
   assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_u  = {instr[31:12], 12'b0};
   assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_sh = {27'b0, instr[24:20]};

   // Field extraction per opcode, then illegal squash and rd==x0 write suppression
   always_comb begin
      logic bad;
      bad = 1'b0;
      dec = '0;
      dec.aluselect = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.rd  = f_rd;
            dec.reg_write = 1'b1;
            if (funct7 == 7'b0000000 ||
                (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5)))
               dec.aluselect = alu_from_funct3(funct3, funct7[5]);
            else
               bad = 1'b1;
         end
         OPC_OP_IMM: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.src1_imm  = 1'b1;
            dec.reg_write = 1'b1;
            if (funct3 == 3'd1) begin
               dec.aluselect = ALU_SLL;
               dec.imm = imm_sh;
               bad = (funct7 != 7'b0000000);
            end else if (funct3 == 3'd5) begin
               dec.aluselect = alu_from_funct3(funct3, funct7[5]);
               dec.imm = imm_sh;
               bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
            end else begin
               dec.aluselect = alu_from_funct3(funct3, 1'b0);
               dec.imm = imm_i;
            end
         end
         OPC_LUI: begin
            dec.rd = f_rd;
            dec.aluselect = ALU_PASS1;
            dec.src1_imm  = 1'b1;
            dec.imm = imm_u;
            dec.reg_write = 1'b1;
         end
         OPC_AUIPC: begin
            dec.rd = f_rd;
            dec.src0_pc  = 1'b1;
            dec.src1_imm = 1'b1;
            dec.imm = imm_u;
            dec.reg_write = 1'b1;
         end
         OPC_JAL: begin
            dec.rd = f_rd;
            dec.src0_pc  = 1'b1;
            dec.src1_imm = 1'b1;
            dec.imm = imm_j;
            dec.reg_write = 1'b1;
            dec.jump = 1'b1;
         end
         OPC_JALR: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.src1_imm = 1'b1;
            dec.imm = imm_i;
            dec.reg_write = 1'b1;
            dec.jump = 1'b1;
            bad = (funct3 != 3'd0);
         end
         OPC_LOAD: begin
            dec.rs1 = f_rs1;
            dec.rd  = f_rd;
            dec.src1_imm = 1'b1;
            dec.imm = imm_i;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            bad = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OPC_STORE: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.src1_imm  = 1'b1;
            dec.imm = imm_s;
            dec.mem_write = 1'b1;
            bad = (funct3 > 3'd2);
         end
         OPC_BRANCH: begin
            dec.rs1 = f_rs1;
            dec.rs2 = f_rs2;
            dec.imm = imm_b;
            dec.branch = 1'b1;
            case (funct3)
               3'd0: dec.aluselect = ALU_EQ;
               3'd1: begin
                  dec.aluselect = ALU_EQ;
                  dec.branch_invert = 1'b1;
               end
               3'd4: dec.aluselect = ALU_SLT;
               3'd5: dec.aluselect = ALU_SGE;
               3'd6: dec.aluselect = ALU_SLTU;
               3'd7: dec.aluselect = ALU_SGEU;
               default: bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase

      if (bad) begin
         dec = '0;
         dec.aluselect = ALU_ADD;
         dec.illegal = 1'b1;
      end
      if (dec.rd == 5'd0)
         dec.reg_write = 1'b0;
   end

endmodule

// File: rtl/alu_decode_stage.sv
// Decode stage: decodes fetched words and presents them to execute through
// a 2-entry skid buffer (main register at the output, skid behind it).
// in_ready is a flop, so there is no combinational path from out_ready.
module alu_decode_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   alu_decode_stage_if.slave bus
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      decoded_t              dec;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_e;

   state_e   state_q;
   state_e   state_d;
   logic     in_ready_q;
   logic     in_ready_d;
   logic     in_fire;
   logic     out_fire;
   logic     load_main_in;
   logic     load_main_skid;
   logic     load_skid_in;
   decoded_t dec_new;
   entry_t   entry_new;
   entry_t   main_q;
   entry_t   skid_q;

   rv32_decoder u_dec (
      .instr (bus.in_instr),
      .dec   (dec_new)
   );

   assign entry_new = '{pc: bus.in_pc, dec: dec_new};

   // Occupancy transitions; flush overrides and refuses the offered word
   always_comb begin
      state_d        = state_q;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
      in_fire        = bus.in_valid & in_ready_q & ~flush;
      out_fire       = (state_q != S_EMPTY) & bus.out_ready;
      if (flush) begin
         state_d = S_EMPTY;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_fire) begin
                  load_main_in = 1'b1;
                  state_d = S_ONE;
               end
            end
            S_ONE: begin
               // Simultaneous in/out: the new word replaces the departing head
               if (in_fire && out_fire) begin
                  load_main_in = 1'b1;
               end else if (in_fire) begin
                  load_skid_in = 1'b1;
                  state_d = S_FULL;
               end else if (out_fire) begin
                  state_d = S_EMPTY;
               end
            end
            S_FULL: begin
               // in_ready is low here, so only the skid-to-main move happens
               if (out_fire) begin
                  load_main_skid = 1'b1;
                  state_d = S_ONE;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      in_ready_d = (state_d != S_FULL);
   end

   // Occupancy state and registered in_ready
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
      end
   end

   // Entry storage: main feeds the outputs, skid holds the second entry
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)
            main_q <= entry_new;
         else if (load_main_skid)
            main_q <= skid_q;
         if (load_skid_in)
            skid_q <= entry_new;
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.out_valid         = (state_q != S_EMPTY);
   assign bus.out_pc            = main_q.pc;
   assign bus.out_aluselect     = main_q.dec.aluselect;
   assign bus.out_rs1           = main_q.dec.rs1;
   assign bus.out_rs2           = main_q.dec.rs2;
   assign bus.out_rd            = main_q.dec.rd;
   assign bus.out_imm           = main_q.dec.imm;
   assign bus.out_src0_pc       = main_q.dec.src0_pc;
   assign bus.out_src1_imm      = main_q.dec.src1_imm;
   assign bus.out_reg_write     = main_q.dec.reg_write;
   assign bus.out_mem_read      = main_q.dec.mem_read;
   assign bus.out_mem_write     = main_q.dec.mem_write;
   assign bus.out_branch        = main_q.dec.branch;
   assign bus.out_jump          = main_q.dec.jump;
   assign bus.out_branch_invert = main_q.dec.branch_invert;
   assign bus.out_illegal       = main_q.dec.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Scoreboard bench for alu_decode_stage: the driver queues hand-computed
// bundles on each accepted word, the monitor pops and compares on transfer.
module tb_alu_decode_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   alu_decode_stage_if #(.DATA_WIDTH(32)) bus ();

   alu_decode_stage #(.DATA_WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // {src0_pc, src1_imm, reg_write, mem_read, mem_write, branch, jump, branch_invert, illegal}
   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  alu;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [8:0]  fl;
   } obs_t;

   obs_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   obs_t        vec_exp[11];
   logic [31:0] vec_ins[11];
   obs_t        held;
   logic        stalled = 1'b0;

   function automatic obs_t mk(input logic [3:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [31:0] imm, input logic [8:0] fl);
      obs_t o;
      o.pc = '0; o.alu = alu; o.rs1 = rs1; o.rs2 = rs2; o.rd = rd; o.imm = imm; o.fl = fl;
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.pc  = bus.out_pc;
      o.alu = bus.out_aluselect;
      o.rs1 = bus.out_rs1;
      o.rs2 = bus.out_rs2;
      o.rd  = bus.out_rd;
      o.imm = bus.out_imm;
      o.fl  = {bus.out_src0_pc, bus.out_src1_imm, bus.out_reg_write, bus.out_mem_read,
               bus.out_mem_write, bus.out_branch, bus.out_jump, bus.out_branch_invert,
               bus.out_illegal};
      return o;
   endfunction

   task automatic check_bit(input string name, input logic got, input logic exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic check_obs(input string name, input obs_t got, input obs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got pc=%h alu=%0d rs1=%0d rs2=%0d rd=%0d imm=%h fl=%b expected pc=%h alu=%0d rs1=%0d rs2=%0d rd=%0d imm=%h fl=%b",
                  name, got.pc, got.alu, got.rs1, got.rs2, got.rd, got.imm, got.fl,
                  exp.pc, exp.alu, exp.rs1, exp.rs2, exp.rd, exp.imm, exp.fl);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Monitor: pop on transfer, and require a stalled bundle to stay put
   always @(negedge clk) begin
      if (stalled) begin
         check_bit("hold_valid", bus.out_valid, 1'b1);
         check_obs("hold_fields", sample(), held);
      end
      stalled = 1'b0;
      if (rst_n && !flush && bus.out_valid) begin
         if (bus.out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_output: got pc=%h expected no output", bus.out_pc);
            end else begin
               check_obs("output", sample(), sb.pop_front());
            end
         end else begin
            stalled = 1'b1;
            held = sample();
         end
      end
   end

   task automatic send(input logic [31:0] ins, input logic [31:0] pc, input obs_t e);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      bus.in_pc    = pc;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (done) begin
         e.pc = pc;
         sb.push_back(e);
      end else begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance of %h", ins);
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check_int(name, sb.size(), 0);
   endtask

   initial begin
      vec_ins[0]  = 32'h00510093; vec_exp[0]  = mk(4'd0,  5'd2, 5'd0, 5'd1, 32'h00000005, 9'b011000000);
      vec_ins[1]  = 32'h405201B3; vec_exp[1]  = mk(4'd1,  5'd4, 5'd5, 5'd3, 32'h00000000, 9'b001000000);
      vec_ins[2]  = 32'h4030D093; vec_exp[2]  = mk(4'd4,  5'd1, 5'd0, 5'd1, 32'h00000003, 9'b011000000);
      vec_ins[3]  = 32'h123452B7; vec_exp[3]  = mk(4'd13, 5'd0, 5'd0, 5'd5, 32'h12345000, 9'b011000000);
      vec_ins[4]  = 32'hFE209EE3; vec_exp[4]  = mk(4'd10, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 9'b000001010);
      vec_ins[5]  = 32'h00000000; vec_exp[5]  = mk(4'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 9'b000000001);
      vec_ins[6]  = 32'h00000013; vec_exp[6]  = mk(4'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 9'b010000000);
      vec_ins[7]  = 32'h40009093; vec_exp[7]  = mk(4'd0,  5'd0, 5'd0, 5'd0, 32'h00000000, 9'b000000001);
      vec_ins[8]  = 32'h008000EF; vec_exp[8]  = mk(4'd0,  5'd0, 5'd0, 5'd1, 32'h00000008, 9'b111000100);
      vec_ins[9]  = 32'h0020A223; vec_exp[9]  = mk(4'd0,  5'd1, 5'd2, 5'd0, 32'h00000004, 9'b010010000);
      vec_ins[10] = 32'hFF80A183; vec_exp[10] = mk(4'd0,  5'd1, 5'd0, 5'd3, 32'hFFFFFFF8, 9'b011100000);

      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_bit("reset_out_valid", bus.out_valid, 1'b0);
      check_bit("reset_in_ready", bus.in_ready, 1'b1);
      check_obs("reset_fields", sample(), '0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Streaming decode with execute always ready
      bus.out_ready = 1'b1;
      send(vec_ins[0], 32'h00001000, vec_exp[0]);
      check_bit("latency_out_valid", bus.out_valid, 1'b1);
      for (int i = 1; i < 11; i++)
         send(vec_ins[i], 32'h00001000 + 32'(4 * i), vec_exp[i]);
      drain("stream_drain");

      // Backpressure: two accepted, third held until execute drains
      bus.out_ready = 1'b0;
      send(vec_ins[1], 32'h00002000, vec_exp[1]);
      check_bit("bp_ready_after_first", bus.in_ready, 1'b1);
      send(vec_ins[2], 32'h00002004, vec_exp[2]);
      check_bit("bp_ready_after_second", bus.in_ready, 1'b0);
      check_bit("bp_out_valid", bus.out_valid, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_instr = vec_ins[3];
      bus.in_pc    = 32'h00002008;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_bit("bp_ready_full", bus.in_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(vec_ins[3], 32'h00002008, vec_exp[3]);
      drain("bp_drain");

      // Flush while full, offering a word in the flush cycle
      bus.out_ready = 1'b0;
      send(vec_ins[0], 32'h00003000, vec_exp[0]);
      send(vec_ins[1], 32'h00003004, vec_exp[1]);
      bus.in_valid = 1'b1;
      bus.in_instr = vec_ins[4];
      bus.in_pc    = 32'h00003008;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      check_bit("flush_full_out_valid", bus.out_valid, 1'b0);
      check_bit("flush_full_in_ready", bus.in_ready, 1'b1);

      // Flush with one entry while in_ready is high: offered word must vanish
      send(vec_ins[10], 32'h00003010, vec_exp[10]);
      bus.in_valid = 1'b1;
      bus.in_instr = vec_ins[8];
      bus.in_pc    = 32'h00003014;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      bus.in_valid = 1'b0;
      sb.delete();
      check_bit("flush_one_out_valid", bus.out_valid, 1'b0);
      check_bit("flush_one_in_ready", bus.in_ready, 1'b1);
      bus.out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check_bit("flush_dropped", bus.out_valid, 1'b0);

      // Reset mid-stream with a full buffer
      bus.out_ready = 1'b0;
      send(vec_ins[0], 32'h00004000, vec_exp[0]);
      send(vec_ins[1], 32'h00004004, vec_exp[1]);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      check_bit("midreset_out_valid", bus.out_valid, 1'b0);
      check_bit("midreset_in_ready", bus.in_ready, 1'b1);
      check_obs("midreset_fields", sample(), '0);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      send(vec_ins[9], 32'h00004010, vec_exp[9]);
      drain("post_reset_drain");

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

endmodule
